// File: rtl/stack_arb_pkg.sv
// Shared types and helpers for the two-requester stack arbiter.
package stack_arb_pkg;

  localparam int unsigned DW_DEF = 4;

  typedef enum logic [1:0] {
    OP_ILL  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_SWAP = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // An op is refused when the LIFO cannot honour it, or when it is not a real op.
  function automatic logic op_rejected(input op_e op, input logic full, input logic empty);
    case (op)
      OP_PUSH:          return full;
      OP_POP, OP_SWAP:  return empty;
      default:          return 1'b1;
    endcase
  endfunction

  function automatic logic op_pushes(input op_e op);
    return (op == OP_PUSH) || (op == OP_SWAP);
  endfunction

  function automatic logic op_pops(input op_e op);
    return (op == OP_POP) || (op == OP_SWAP);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic       gnt_c
);

  logic last_q;

  always_comb begin
    gnt_c = req[1];
    if (req == 2'b11) gnt_c = ~last_q;
  end

  // Reset points at requester 1 so requester 0 takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      last_q <= 1'b1;
    else if (adv) last_q <= gnt_c;
  end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates two requesters onto one shared 8-deep LIFO, one op per 3-cycle slot.
// Define STACK_ARB_ERRCNT_EN to add the saturating rejected-op counter err_cnt_o.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_i,
  input  logic [1:0]    op0_i,
  input  logic [1:0]    op1_i,
  input  logic [DW-1:0] din0_i,
  input  logic [DW-1:0] din1_i,
  output logic [1:0]    ack_o,
  output logic [DW-1:0] rsp_data_o,
  output logic          rsp_err_o,
  output logic          stk_push_o,
  output logic          stk_pop_o,
  output logic [DW-1:0] stk_din_o,
  input  logic [DW-1:0] stk_dout_i,
  input  logic          stk_full_i,
  input  logic          stk_empty_i
`ifdef STACK_ARB_ERRCNT_EN
  ,
  output logic [7:0]    err_cnt_o
`endif
);

  state_e        state_q, state_d;
  op_e           op_q, op_d, op_sel;
  logic [DW-1:0] din_q, din_d, din_sel;
  logic          who_q, who_d;
  logic          rej_q, rej_d;
  logic          push_q, push_d;
  logic          pop_q, pop_d;
  logic [1:0]    ack_q, ack_d;
  logic          err_q, err_d;
  logic          rdv_q, rdv_d;
  logic          gnt_c;
  logic          adv_c;

  assign adv_c = (state_q == ST_IDLE) && (|req_i);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_i),
    .adv   (adv_c),
    .gnt_c (gnt_c)
  );

  // Flags only move on an edge that consumes a strobe, so the values seen at
  // grant are the values held throughout the following ISSUE cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    din_d   = din_q;
    who_d   = who_q;
    rej_d   = rej_q;
    push_d  = 1'b0;
    pop_d   = 1'b0;
    ack_d   = 2'b00;
    err_d   = 1'b0;
    rdv_d   = 1'b0;
    op_sel  = gnt_c ? op_e'(op1_i) : op_e'(op0_i);
    din_sel = gnt_c ? din1_i : din0_i;

    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          state_d = ST_ISSUE;
          who_d   = gnt_c;
          op_d    = op_sel;
          din_d   = din_sel;
          rej_d   = op_rejected(op_sel, stk_full_i, stk_empty_i);
          push_d  = !rej_d && op_pushes(op_sel);
          pop_d   = !rej_d && op_pops(op_sel);
        end
      end
      ST_ISSUE: begin
        state_d = ST_RESP;
        ack_d   = who_q ? 2'b10 : 2'b01;
        err_d   = rej_q;
        rdv_d   = !rej_q && op_pops(op_q);
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ILL;
      din_q   <= '0;
      who_q   <= 1'b0;
      rej_q   <= 1'b0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      ack_q   <= 2'b00;
      err_q   <= 1'b0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      din_q   <= din_d;
      who_q   <= who_d;
      rej_q   <= rej_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdv_q   <= rdv_d;
    end
  end

  assign stk_push_o = push_q;
  assign stk_pop_o  = pop_q;
  assign stk_din_o  = din_q;
  assign ack_o      = ack_q;
  assign rsp_err_o  = err_q;
  // LIFO read data lands on the edge entering RESP, so it can only be gated here.
  assign rsp_data_o = rdv_q ? stk_dout_i : '0;

`ifdef STACK_ARB_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              err_cnt_q <= 8'd0;
    else if (err_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule
